// File: rtl/snes_port_serializer.sv
// SNES controller-port serializer: 2 or 4 pads over PORT_DO[1:0], with optional multitap group select.
// Shift registers reload on latch or P6 fall and shift MSB-first on CPU clock rises, then hold FILL_BIT.
module snes_port_serializer #(
  parameter int unsigned NUM_PADS    = 4,
  parameter int unsigned REPORT_BITS = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          FILL_BIT    = 1'b0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            MULTITAP,
  input  logic                            PORT_LATCH,
  input  logic                            PORT_CLK,
  input  logic                            PORT_P6,
  input  logic [NUM_PADS*REPORT_BITS-1:0] PADS,
  output logic [1:0]                      PORT_DO,
  output logic                            POLL_STB,
  output logic [7:0]                      POLL_CNT
);

  localparam int unsigned     CW       = $clog2(REPORT_BITS + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(REPORT_BITS);

  logic [2:0] pins_raw;
  logic [2:0] pins_s;
  logic       l_s, c_s, p_s;

  assign pins_raw = {PORT_P6, PORT_CLK, PORT_LATCH};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign pins_s = pins_raw;
    end else begin : g_sync
      logic [2:0] sync_q [SYNC_STAGES];
      logic [2:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = pins_raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge CLK) begin
        if (RESET) sync_q <= '{default: '0};
        else       sync_q <= sync_d;
      end

      assign pins_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign l_s = pins_s[0];
  assign c_s = pins_s[1];
  assign p_s = pins_s[2];

  // Report source per channel: group 1 (pads 2/3) only when a multitap is present and P6 is low.
  logic [REPORT_BITS-1:0] pad_sel [2];

  generate
    if (NUM_PADS == 4) begin : g_tap
      logic grp;
      assign grp        = MULTITAP & ~p_s;
      assign pad_sel[0] = grp ? PADS[2*REPORT_BITS +: REPORT_BITS] : PADS[0 +: REPORT_BITS];
      assign pad_sel[1] = grp ? PADS[3*REPORT_BITS +: REPORT_BITS] : PADS[REPORT_BITS +: REPORT_BITS];
    end else begin : g_notap
      assign pad_sel[0] = PADS[0 +: REPORT_BITS];
      assign pad_sel[1] = PADS[REPORT_BITS +: REPORT_BITS];
    end
  endgenerate

  logic [REPORT_BITS-1:0] sr_q  [2];
  logic [REPORT_BITS-1:0] sr_d  [2];
  logic [CW-1:0]          cnt_q [2];
  logic [CW-1:0]          cnt_d [2];
  logic                   l_prev_q, c_prev_q, p_prev_q;
  logic [1:0]             do_q, do_d;
  logic                   stb_q, stb_d;
  logic [7:0]             poll_cnt_q, poll_cnt_d;
  logic                   l_fall, c_rise, p_fall;
  logic [1:0]             data;

  always_comb begin
    l_fall = l_prev_q & ~l_s;
    c_rise = c_s & ~c_prev_q;
    p_fall = MULTITAP & p_prev_q & ~p_s;
    data   = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      sr_d[k]  = sr_q[k];
      cnt_d[k] = cnt_q[k];
      // Reload outranks shifting, so a clock rise coincident with a P6 fall is dropped.
      if (l_s || p_fall) begin
        sr_d[k]  = ~pad_sel[k];
        cnt_d[k] = '0;
      end else if (c_rise && (cnt_q[k] < CNT_FULL)) begin
        sr_d[k]  = sr_q[k] << 1;
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
      data[k] = (cnt_d[k] == CNT_FULL) ? FILL_BIT : sr_d[k][REPORT_BITS-1];
    end
    do_d       = {~MULTITAP | (data[1] & ~l_s), data[0]};
    stb_d      = l_fall;
    poll_cnt_d = poll_cnt_q + 8'(l_fall);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr_q       <= '{default: '1};
      cnt_q      <= '{default: '0};
      l_prev_q   <= 1'b0;
      c_prev_q   <= 1'b0;
      p_prev_q   <= 1'b0;
      do_q       <= 2'b11;
      stb_q      <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      l_prev_q   <= l_s;
      c_prev_q   <= c_s;
      p_prev_q   <= p_s;
      do_q       <= do_d;
      stb_q      <= stb_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign PORT_DO  = do_q;
  assign POLL_STB = stb_q;
  assign POLL_CNT = poll_cnt_q;

endmodule

// File: tb/tb_snes_port_serializer.sv
// Directed bench for snes_port_serializer: a 4-pad/16-bit/2-sync instance and a
// 2-pad/32-bit/0-sync/fill-1 instance share the CPU-side pins.
module tb_snes_port_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mt, latch, pclk, p6;
  logic [63:0] pads1;
  logic [31:0] pads2;
  logic [1:0]  do1, do2;
  logic        stb1, stb2;
  logic [7:0]  cnt1, cnt2;

  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned polls_exp = 0;

  snes_port_serializer #(
    .NUM_PADS(4), .REPORT_BITS(16), .SYNC_STAGES(2), .FILL_BIT(1'b0)
  ) dut (
    .CLK(clk), .RESET(rst), .MULTITAP(mt), .PORT_LATCH(latch), .PORT_CLK(pclk),
    .PORT_P6(p6), .PADS(pads1), .PORT_DO(do1), .POLL_STB(stb1), .POLL_CNT(cnt1)
  );

  snes_port_serializer #(
    .NUM_PADS(2), .REPORT_BITS(32), .SYNC_STAGES(0), .FILL_BIT(1'b1)
  ) dut2 (
    .CLK(clk), .RESET(rst), .MULTITAP(mt), .PORT_LATCH(latch), .PORT_CLK(pclk),
    .PORT_P6(p6), .PADS({32'h0, pads2}), .PORT_DO(do2), .POLL_STB(stb2), .POLL_CNT(cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level after n clock rises: active-low report bit, then fill.
  function automatic logic exp16(input logic [15:0] v, input int unsigned n);
    return (n < 16) ? ~v[15-n] : 1'b0;
  endfunction

  function automatic logic exp32(input logic [31:0] v, input int unsigned n);
    return (n < 32) ? ~v[31-n] : 1'b1;
  endfunction

  task automatic tick(input int unsigned k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    pclk = 1'b1; tick(2);
    pclk = 1'b0; tick(2);
  endtask

  task automatic latch_fall();
    latch = 1'b0;
    tick(1);
    check_eq("stb2_on", stb2, 1'b1);
    check_eq("stb1_early", stb1, 1'b0);
    tick(1);
    check_eq("stb2_off", stb2, 1'b0);
    tick(1);
    check_eq("stb1_on", stb1, 1'b1);
    tick(1);
    check_eq("stb1_off", stb1, 1'b0);
    polls_exp = (polls_exp + 1) % 256;
    check_eq("poll_cnt1", cnt1, polls_exp);
    check_eq("poll_cnt2", cnt2, polls_exp);
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    tick(3);
    latch_fall();
  endtask

  task automatic run_report16(input logic [15:0] a, input logic [15:0] b, input int unsigned start);
    for (int unsigned n = start; n <= 18; n++) begin
      check_eq($sformatf("do0_n%0d", n), do1[0], exp16(a, n));
      check_eq($sformatf("do1_n%0d", n), do1[1], mt ? exp16(b, n) : 1'b1);
      if (n < 18) pulse();
    end
  endtask

  initial begin
    rst = 1'b1; mt = 1'b0; latch = 1'b0; pclk = 1'b0; p6 = 1'b0;
    pads1 = '0; pads2 = '0;
    tick(2);
    check_eq("rst_do1", do1, 2'b11);
    check_eq("rst_do2", do2, 2'b11);
    check_eq("rst_cnt1", cnt1, 8'd0);
    check_eq("rst_cnt2", cnt2, 8'd0);
    check_eq("rst_stb1", stb1, 1'b0);
    rst = 1'b0;

    // Standard read, no multitap, plus 3-clock latency through the sync chain
    pads1[15:0] = 16'h8001;
    pads2       = 32'hA5C3_0F96;
    latch_pulse();
    check_eq("std_first", do1[0], exp16(16'h8001, 0));
    pclk = 1'b1;
    tick(2);
    check_eq("lat3_hold", do1[0], exp16(16'h8001, 0));
    tick(1);
    check_eq("lat3_move", do1[0], exp16(16'h8001, 1));
    pclk = 1'b0;
    tick(2);
    run_report16(16'h8001, 16'h0000, 1);

    // Multitap: group 0 while P6 high, then group 1 after P6 falls
    mt = 1'b1; p6 = 1'b1;
    pads1 = {16'hC000, 16'h0030, 16'h000C, 16'h0003};
    latch = 1'b1;
    tick(4);
    check_eq("mt_id", do1[1], 1'b0);
    check_eq("mt_latched_do0", do1[0], exp16(16'h0003, 0));
    latch_fall();
    run_report16(16'h0003, 16'h000C, 0);
    p6 = 1'b0;
    tick(4);
    run_report16(16'h0030, 16'hC000, 0);

    // P6 fall and clock rise in the same cycle: reload wins
    p6 = 1'b1;
    tick(4);
    latch_pulse();
    pulse();
    pulse();
    pads1[47:32] = 16'h8000;
    p6 = 1'b0; pclk = 1'b1;
    tick(2);
    pclk = 1'b0;
    tick(2);
    run_report16(16'h8000, 16'hC000, 0);

    // Latch dominance: clocks ignored, pad change picked up while latched
    mt = 1'b0; p6 = 1'b1;
    pads1[15:0] = 16'h0000;
    latch = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      pulse();
      if (i == 2) pads1[15:0] = 16'h8000;
    end
    latch_fall();
    run_report16(16'h8000, 16'h0000, 0);

    // 32-bit instance: 1-clock latency, 32 bits, then fill 1
    latch_pulse();
    check_eq("w32_first", do2[0], exp32(pads2, 0));
    pclk = 1'b1;
    tick(1);
    check_eq("lat1_move", do2[0], exp32(pads2, 1));
    tick(1);
    pclk = 1'b0;
    tick(2);
    for (int unsigned n = 1; n <= 34; n++) begin
      check_eq($sformatf("w32_do0_n%0d", n), do2[0], exp32(pads2, n));
      check_eq($sformatf("w32_do1_n%0d", n), do2[1], 1'b1);
      if (n < 34) pulse();
    end

    // Poll counter wrap
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    polls_exp = 0;
    check_eq("rst2_do1", do1, 2'b11);
    check_eq("rst2_cnt1", cnt1, 8'd0);
    repeat (255) begin
      latch = 1'b1; tick(1);
      latch = 1'b0; tick(1);
    end
    tick(4);
    check_eq("polls255_1", cnt1, 8'd255);
    check_eq("polls255_2", cnt2, 8'd255);
    latch = 1'b1; tick(1);
    latch = 1'b0; tick(4);
    check_eq("wrap_1", cnt1, 8'd0);
    check_eq("wrap_2", cnt2, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
